// File: rtl/factorial_accel_if.sv
// Bus-side view of the factorial accelerator: decoded write strobe, word address,
// write/read data and the exported status flags.
interface factorial_accel_if;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output we,
        output a,
        output wd,
        input  rd,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  we,
        input  a,
        input  wd,
        output rd,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/factorial_accel.sv
// Memory-mapped iterative factorial accelerator: one multiply per cycle in CALC,
// result latched in FIN, sticky done/err flags for the SoC status path.
module factorial_accel #(
    parameter int NBITS  = 4,
    parameter int RWIDTH = 32,
    parameter int MAXN   = 12
) (
    input  logic               clk,
    input  logic               reset,
    factorial_accel_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [NBITS-1:0]  MAXN_W  = NBITS'(MAXN);
    localparam logic [NBITS-1:0]  ONE_N   = NBITS'(1);
    localparam logic [RWIDTH-1:0] ONE_ACC = RWIDTH'(1);

    state_t              state;
    logic [NBITS-1:0]    nReg;
    logic [NBITS-1:0]    cnt;
    logic [RWIDTH-1:0]   acc;
    logic [RWIDTH-1:0]   result;
    logic                busyReg;
    logic                doneReg;
    logic                errReg;
    logic                errPend;
    logic                errWait;

    logic                nWrite;
    logic                goWrite;
    logic [31:0]         rdMux;
    logic                unusedWd;

    function automatic logic [RWIDTH-1:0] mulTrunc(
        input logic [RWIDTH-1:0] x,
        input logic [NBITS-1:0]  y
    );
        logic [RWIDTH+NBITS-1:0] p;
        p = {{NBITS{1'b0}}, x} * {{RWIDTH{1'b0}}, y};
        return p[RWIDTH-1:0];
    endfunction

    // Register writes are only honoured in IDLE so a running job cannot be disturbed.
    assign nWrite  = bus.we && (bus.a == 2'd0) && (state == IDLE);
    assign goWrite = bus.we && (bus.a == 2'd1) && bus.wd[0] && (state == IDLE);

    assign unusedWd = ^bus.wd[31:NBITS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            nReg    <= '0;
            cnt     <= '0;
            acc     <= ONE_ACC;
            result  <= '0;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
            errReg  <= 1'b0;
            errPend <= 1'b0;
            errWait <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (nWrite) begin
                        nReg <= bus.wd[NBITS-1:0];
                    end
                    if (goWrite) begin
                        doneReg <= 1'b0;
                        errReg  <= 1'b0;
                        if (nReg > MAXN_W) begin
                            // Error jobs spend one extra FIN cycle so they complete
                            // with the same 2-cycle latency as the shortest valid job.
                            errPend <= 1'b1;
                            errWait <= 1'b1;
                            state   <= FIN;
                        end else begin
                            acc     <= ONE_ACC;
                            cnt     <= nReg;
                            busyReg <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt <= ONE_N) begin
                        busyReg <= 1'b0;
                        state   <= FIN;
                    end else begin
                        acc <= mulTrunc(acc, cnt);
                        cnt <= cnt - ONE_N;
                    end
                end
                FIN: begin
                    if (errWait) begin
                        errWait <= 1'b0;
                    end else begin
                        if (errPend) begin
                            result <= '0;
                            errReg <= 1'b1;
                        end else begin
                            result <= acc;
                        end
                        doneReg <= 1'b1;
                        errPend <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rdMux = '0;
        case (bus.a)
            2'd0:    rdMux = {{(32-NBITS){1'b0}}, nReg};
            2'd1:    rdMux = {31'b0, busyReg};
            2'd2:    rdMux = {29'b0, errReg, busyReg, doneReg};
            default: rdMux = 32'(result);
        endcase
    end

    assign bus.rd   = rdMux;
    assign bus.busy = busyReg;
    assign bus.done = doneReg;
    assign bus.err  = errReg;
endmodule

// File: tb/tb_factorial_accel.sv
// Directed bench for factorial_accel: register map, latencies, error path,
// ignored mid-flight writes and asynchronous abort.
module tb_factorial_accel;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    factorial_accel_if bus();

    factorial_accel #(
        .NBITS (4),
        .RWIDTH(32),
        .MAXN  (12)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.we = 1'b1;
        bus.a  = addr;
        bus.wd = data;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] v);
        bus.a = addr;
        #1;
        v = bus.rd;
    endtask

    // Call right after the GO write; counts edges until done and CALC cycles seen.
    task automatic waitDone(output int lat, output int busyCycles);
        lat = 0;
        busyCycles = bus.busy ? 1 : 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) busyCycles++;
        end
        if (lat >= 100) checkEq("doneTimeout", 32'(lat), 32'd0);
    endtask

    task automatic runJob(input string tag, input logic [3:0] n, input logic [31:0] expRes,
                          input int expLat);
        int lat;
        int bc;
        logic [31:0] v;
        busWrite(2'd0, {28'b0, n});
        busWrite(2'd1, 32'd1);
        waitDone(lat, bc);
        checkEq({tag, "_lat"}, 32'(lat), 32'(expLat));
        readReg(2'd3, v);
        checkEq({tag, "_res"}, v, expRes);
    endtask

    initial begin
        logic [31:0] v;
        int lat;
        int bc;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.we = 1'b0;
        bus.a  = 2'd0;
        bus.wd = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            readReg(2'(i), v);
            checkEq($sformatf("rstRd%0d", i), v, 32'd0);
        end
        checkEq("rstBusy", 32'(bus.busy), 32'd0);
        checkEq("rstDone", 32'(bus.done), 32'd0);
        checkEq("rstErr",  32'(bus.err),  32'd0);

        // 5! = 120
        busWrite(2'd0, 32'd5);
        busWrite(2'd1, 32'd1);
        waitDone(lat, bc);
        checkEq("n5Lat",  32'(lat), 32'd6);
        checkEq("n5Busy", 32'(bc),  32'd5);
        readReg(2'd3, v);
        checkEq("n5Res", v, 32'h0000_0078);
        readReg(2'd2, v);
        checkEq("n5Status", v, 32'h1);

        runJob("n0", 4'd0, 32'd1, 2);
        runJob("n1", 4'd1, 32'd1, 2);

        // 12! = 479001600; old result visible and busy readable while computing
        busWrite(2'd0, 32'd12);
        busWrite(2'd1, 32'd1);
        readReg(2'd3, v);
        checkEq("n12OldRes", v, 32'd1);
        readReg(2'd1, v);
        checkEq("n12GoBusy", v, 32'd1);
        waitDone(lat, bc);
        checkEq("n12Lat", 32'(lat), 32'd13);
        readReg(2'd3, v);
        checkEq("n12Res", v, 32'h1C8C_FC00);

        // Operand above MAXN
        busWrite(2'd0, 32'd13);
        busWrite(2'd1, 32'd1);
        waitDone(lat, bc);
        checkEq("n13Lat",  32'(lat), 32'd2);
        checkEq("n13Busy", 32'(bc),  32'd0);
        checkEq("n13Err",  32'(bus.err), 32'd1);
        readReg(2'd3, v);
        checkEq("n13Res", v, 32'd0);
        readReg(2'd2, v);
        checkEq("n13Status", v, 32'h5);

        // Writes while busy are dropped
        busWrite(2'd0, 32'd6);
        busWrite(2'd1, 32'd1);
        busWrite(2'd0, 32'd3);
        busWrite(2'd1, 32'd1);
        waitDone(lat, bc);
        checkEq("n6Lat", 32'(lat), 32'd5);
        readReg(2'd3, v);
        checkEq("n6Res", v, 32'h0000_02D0);
        readReg(2'd0, v);
        checkEq("n6N", v, 32'd6);
        readReg(2'd2, v);
        checkEq("n6Status", v, 32'h1);

        // GO with bit0 clear leaves everything alone
        busWrite(2'd1, 32'hFFFF_FFFE);
        @(posedge clk);
        #1;
        readReg(2'd2, v);
        checkEq("goZeroStatus", v, 32'h1);

        // Asynchronous abort in the third CALC cycle
        busWrite(2'd0, 32'd7);
        busWrite(2'd1, 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkEq("abortPreBusy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        checkEq("abortBusy", 32'(bus.busy), 32'd0);
        checkEq("abortDone", 32'(bus.done), 32'd0);
        readReg(2'd3, v);
        checkEq("abortRes", v, 32'd0);
        readReg(2'd0, v);
        checkEq("abortN", v, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Same-cycle write and read: rd shows the pre-edge N
        @(negedge clk);
        bus.we = 1'b1;
        bus.a  = 2'd0;
        bus.wd = 32'd4;
        #1;
        checkEq("rawPre", bus.rd, 32'd0);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        checkEq("rawPost", bus.rd, 32'd4);
        busWrite(2'd1, 32'd1);
        waitDone(lat, bc);
        checkEq("n4Lat", 32'(lat), 32'd5);
        readReg(2'd3, v);
        checkEq("n4Res", v, 32'h0000_0018);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/factorial_accel.md
Name: factorial_accel

Overview:
- Memory-mapped iterative factorial accelerator on the processor data bus, downstream of the MEM stage.
- The SoC address decoder drives the write-enable when the accelerator region is selected; aluout supplies the address and writedata the write data. The block returns rd, which the decoder muxes into readdata.
- done and busy are also exported for the SoC factorial_done / status path.

Parameters:
- NBITS, 4, width of the operand register N.
- RWIDTH, 32, width of the result and accumulator.
- MAXN, 12, largest n whose n! fits in RWIDTH bits. Any larger operand is an error.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- we  input  1  bus write strobe, already qualified by the decoder select.
- a  input  2  word address (bus address bits 3:2).
- wd  input  32  bus write data.
- rd  output  32  bus read data, combinational on a.
- busy  output  1  high while the FSM is in CALC.
- done  output  1  sticky completion flag.
- err  output  1  sticky error flag (n > MAXN).

Behaviour:
- Register map:
  - a=0: N, R/W, bits NBITS-1:0; reads return N zero-extended.
  - a=1: GO, W. Writing with wd[0]=1 starts a computation. Reads return {31'b0, busy}.
  - a=2: STATUS, R. Reads return {29'b0, err, busy, done}. Writes are ignored.
  - a=3: RESULT, R. Reads return the result register. Writes are ignored.
- Reset (reset=0, asynchronous): state=IDLE, N=0, acc=1, cnt=0, result=0. busy, done and err are all 0, so rd reads 0 for a=1/2/3.
- FSM states: IDLE, CALC, FIN.
- IDLE, GO written with wd[0]=1:
  - Clear done and err at that same edge.
  - If N > MAXN: go to FIN with err flagged.
  - Otherwise load acc=1, cnt=N and go to CALC.
- IDLE, GO written with wd[0]=0: no effect.
- CALC, cnt <= 1: go to FIN.
- CALC, otherwise: acc <= acc * cnt (product truncated to RWIDTH, which cannot overflow for n <= MAXN) and cnt <= cnt - 1.
- FIN, one cycle:
  - Error path: result <= 0, err <= 1, done <= 1.
  - Normal path: result <= acc, done <= 1.
  - Then return to IDLE.
- Latency, counting from the GO write edge to the edge at which done becomes 1:
  - Valid n: max(n,1) + 1 cycles. Examples: n=0 gives 2, n=1 gives 2, n=5 gives 6.
  - Error: 2 cycles.
- busy is 1 exactly during CALC cycles.
- Writes to N or GO while the state is not IDLE are ignored, so a computation cannot be restarted or corrupted mid-flight.
- The result register holds the previous value until FIN. RESULT reads during a computation return the old result.
- done and err stay set until the next accepted GO or reset.
- A write and a read on the same cycle: rd reflects the pre-edge register contents.
- Reset asserted mid-computation aborts immediately to the reset state. There is no partial result and done stays 0.

Test Plan:
- Reset, then read a=0..3 -> all reads return 0. busy=0, done=0, err=0.
- Write N=5, write GO=1 -> busy=1 for 5 cycles. done=1 on the 6th edge after GO. RESULT=0x00000078. STATUS=0x1.
- N=0, then separately N=1, then N=12, each started with GO -> RESULT=1, 1 and 0x1C8CFC00 respectively. done latency is 2, 2 and 13 cycles.
- N=13, GO -> done=1 and err=1 after 2 cycles. busy never asserts. RESULT=0. STATUS=0x5.
- N=6, GO, then write N=3 and GO again while busy -> second writes are ignored. RESULT=0x2D0 (720) and N reads back 6.
- N=7, GO, assert reset low at cycle 3 of CALC -> state returns to IDLE asynchronously. RESULT=0, done=0, busy=0. A new N=4/GO afterwards yields 0x18.
